// File: rtl/aes_block_loader.sv
// Collects a cipher key and one 128-bit block from a 32-bit word stream and pulses start to the AES round FSM.
// cfg-to-start is 9/11/13 cycles with a full key load, or 5 on key reuse; in_valid gaps stall the load and outputs hold until core_done.
module aes_block_loader (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [1:0]   cfg_mode,
    input  logic         cfg_enc_dec,
    input  logic         cfg_reuse_key,
    output logic         cfg_err,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic [255:0] key,
    output logic [127:0] block,
    output logic [1:0]   mode,
    output logic         enc_dec,
    output logic [3:0]   roundAmount,
    output logic         start,
    input  logic         core_done,
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_BLK, START, WAIT_DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  word_cnt;
    logic        key_valid;
    logic [1:0]  key_mode;
    logic        cfg_fire, in_fire, cfg_bad, reuse_hit, key_last, blk_last;
    logic [2:0]  key_last_idx;
    logic [3:0]  cfg_rounds;

    assign cfg_ready = (state == IDLE) && !reset;
    assign in_ready  = (state == LOAD_KEY) || (state == LOAD_BLK);
    assign busy      = (state != IDLE);

    assign cfg_fire  = cfg_valid && cfg_ready;
    assign in_fire   = in_valid && in_ready;
    assign cfg_bad   = (cfg_mode == 2'b11);
    assign reuse_hit = cfg_reuse_key && key_valid && (cfg_mode == key_mode);
    assign key_last  = (word_cnt == key_last_idx);
    assign blk_last  = (word_cnt == 3'd3);

    always_comb begin
        key_last_idx = 3'd7;
        cfg_rounds   = 4'd14;
        case (mode)
            2'b00:   key_last_idx = 3'd3;
            2'b01:   key_last_idx = 3'd5;
            default: key_last_idx = 3'd7;
        endcase
        case (cfg_mode)
            2'b00:   cfg_rounds = 4'd10;
            2'b01:   cfg_rounds = 4'd12;
            default: cfg_rounds = 4'd14;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (cfg_fire && !cfg_bad) state_nxt = reuse_hit ? LOAD_BLK : LOAD_KEY;
            LOAD_KEY:  if (in_fire && key_last) state_nxt = LOAD_BLK;
            LOAD_BLK:  if (in_fire && blk_last) state_nxt = START;
            START:     state_nxt = WAIT_DONE;
            WAIT_DONE: if (core_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt    <= '0;
            key_valid   <= 1'b0;
            key_mode    <= '0;
            key         <= '0;
            block       <= '0;
            mode        <= '0;
            enc_dec     <= 1'b0;
            roundAmount <= '0;
            start       <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= cfg_fire && cfg_bad;
            start   <= (state == LOAD_BLK) && in_fire && blk_last;

            if (cfg_fire && !cfg_bad) begin
                mode        <= cfg_mode;
                enc_dec     <= cfg_enc_dec;
                roundAmount <= cfg_rounds;
                word_cnt    <= '0;
                // A fresh load starts from a zeroed key so unused low words read as zero.
                if (!reuse_hit) begin
                    key_valid <= 1'b0;
                    key       <= '0;
                end
            end

            if ((state == LOAD_KEY) && in_fire) begin
                for (int i = 0; i < 8; i++)
                    if (word_cnt == 3'(i)) key[255-32*i -: 32] <= in_data;
                if (key_last) begin
                    key_valid <= 1'b1;
                    key_mode  <= mode;
                    word_cnt  <= '0;
                end else begin
                    word_cnt  <= word_cnt + 3'd1;
                end
            end

            if ((state == LOAD_BLK) && in_fire) begin
                for (int i = 0; i < 4; i++)
                    if (word_cnt == 3'(i)) block[127-32*i -: 32] <= in_data;
                word_cnt <= blk_last ? 3'd0 : word_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: known key/block vectors, latency, reuse, illegal cfg, reset and spurious done.
module tb_aes_block_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [1:0]   cfg_mode = 2'b00;
    logic         cfg_enc_dec = 1'b0;
    logic         cfg_reuse_key = 1'b0;
    logic         cfg_err;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic [255:0] key;
    logic [127:0] block;
    logic [1:0]   mode;
    logic         enc_dec;
    logic [3:0]   roundAmount;
    logic         start;
    logic         core_done = 1'b0;
    logic         busy;

    typedef logic [31:0] wv_t [8];

    int vec_cnt = 0;
    int err_cnt = 0;
    int nc = 0;
    int cfg_cyc = 0;
    int start_cyc = 0;
    int start_cnt = 0;
    int err_pulses = 0;
    int s0;

    wv_t k128, k192, k256, blk0, blk1;

    aes_block_loader dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
        .cfg_enc_dec(cfg_enc_dec), .cfg_reuse_key(cfg_reuse_key), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key(key), .block(block), .mode(mode), .enc_dec(enc_dec),
        .roundAmount(roundAmount), .start(start), .core_done(core_done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        nc = nc + 1;
        if (cfg_valid && cfg_ready) cfg_cyc = nc;
        if (start) begin
            start_cnt = start_cnt + 1;
            start_cyc = nc;
        end
        if (cfg_err) err_pulses = err_pulses + 1;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [1:0] m, input logic ed, input logic reuse);
        int n = 0;
        while (!cfg_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cfg_ready_wait", cfg_ready, 1'b1);
        cfg_valid = 1'b1;
        cfg_mode = m;
        cfg_enc_dec = ed;
        cfg_reuse_key = reuse;
        tick();
        cfg_valid = 1'b0;
        cfg_reuse_key = 1'b0;
    endtask

    task automatic load_words(input wv_t w, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) tick();
            end
            in_valid = 1'b1;
            in_data = w[i];
            while (!in_ready && t < 50) begin
                tick();
                t++;
            end
            if (t >= 50) chk("in_ready_wait", in_ready, 1'b1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_start;
        int n = 0;
        while (!start && n < 20) begin
            tick();
            n++;
        end
        chk("start_seen", start, 1'b1);
    endtask

    task automatic finish_op;
        tick();
        chk("wait_busy", busy, 1'b1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done_idle_busy", busy, 1'b0);
        chk("done_idle_cfg_ready", cfg_ready, 1'b1);
    endtask

    initial begin
        k128 = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 0, 0, 0, 0};
        k192 = '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5, 32'h62f8ead2, 32'h522c6b7b, 0, 0};
        k256 = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                 32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
        blk0 = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734, 0, 0, 0, 0};
        blk1 = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff, 0, 0, 0, 0};

        // reset state
        tick(); tick();
        chk("rst_cfg_ready", cfg_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_key", key, 256'h0);
        chk("rst_start", start, 1'b0);
        chk("rst_round", roundAmount, 4'd0);
        reset = 1'b0;
        tick();
        chk("idle_cfg_ready", cfg_ready, 1'b1);
        chk("idle_in_ready", in_ready, 1'b0);

        // spurious done in IDLE
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("idle_done_busy", busy, 1'b0);

        // AES128 encrypt
        s0 = start_cnt;
        send_cfg(2'b00, 1'b0, 1'b0);
        chk("a128_in_ready", in_ready, 1'b1);
        chk("a128_busy", busy, 1'b1);
        chk("a128_round", roundAmount, 4'd10);
        chk("a128_mode", mode, 2'b00);
        load_words(k128, 4, 0);
        core_done = 1'b1;
        load_words(blk0, 4, 0);
        chk("a128_start", start, 1'b1);
        tick();
        core_done = 1'b0;
        chk("a128_start_once", start, 1'b0);
        chk("a128_latency", start_cyc - cfg_cyc, 9);
        chk("a128_key", key, {32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 128'h0});
        chk("a128_block", block, 128'h3243f6a8885a308d313198a2e0370734);
        chk("a128_enc", enc_dec, 1'b0);
        tick();
        chk("a128_spur_busy", busy, 1'b1);
        finish_op();
        chk("a128_start_cnt", start_cnt - s0, 1);

        // AES256 decrypt with stalls
        s0 = start_cnt;
        send_cfg(2'b10, 1'b1, 1'b0);
        chk("a256_round", roundAmount, 4'd14);
        chk("a256_enc", enc_dec, 1'b1);
        load_words(k256, 8, 1);
        load_words(blk1, 4, 1);
        wait_start();
        tick();
        chk("a256_key", key, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        chk("a256_block", block, 128'h00112233445566778899aabbccddeeff);
        finish_op();
        chk("a256_start_cnt", start_cnt - s0, 1);

        // AES192 then key reuse
        send_cfg(2'b01, 1'b0, 1'b0);
        chk("a192_round", roundAmount, 4'd12);
        load_words(k192, 6, 0);
        load_words(blk0, 4, 0);
        wait_start();
        tick();
        chk("a192_latency", start_cyc - cfg_cyc, 11);
        finish_op();
        send_cfg(2'b01, 1'b1, 1'b1);
        chk("reuse_in_ready", in_ready, 1'b1);
        chk("reuse_enc", enc_dec, 1'b1);
        load_words(blk1, 4, 0);
        chk("reuse_start", start, 1'b1);
        tick();
        chk("reuse_latency", start_cyc - cfg_cyc, 5);
        chk("reuse_key", key, {32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
                               32'h62f8ead2, 32'h522c6b7b, 64'h0});
        finish_op();
        send_cfg(2'b00, 1'b0, 1'b1);
        chk("mismatch_key_clr", key, 256'h0);
        load_words(k128, 4, 0);
        load_words(blk0, 4, 0);
        wait_start();
        tick();
        chk("mismatch_latency", start_cyc - cfg_cyc, 9);
        finish_op();

        // illegal config
        s0 = start_cnt;
        send_cfg(2'b11, 1'b1, 1'b0);
        chk("ill_err", cfg_err, 1'b1);
        chk("ill_busy", busy, 1'b0);
        chk("ill_mode", mode, 2'b00);
        chk("ill_enc", enc_dec, 1'b0);
        chk("ill_round", roundAmount, 4'd10);
        tick();
        chk("ill_err_pulse", cfg_err, 1'b0);
        chk("ill_cfg_ready", cfg_ready, 1'b1);
        chk("ill_no_start", start_cnt - s0, 0);

        // reset during LOAD_KEY
        s0 = start_cnt;
        send_cfg(2'b10, 1'b1, 1'b0);
        load_words(k256, 3, 0);
        reset = 1'b1;
        #1;
        chk("mrst_key", key, 256'h0);
        chk("mrst_mode", mode, 2'b00);
        chk("mrst_enc", enc_dec, 1'b0);
        chk("mrst_round", roundAmount, 4'd0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_in_ready", in_ready, 1'b0);
        chk("mrst_cfg_ready", cfg_ready, 1'b0);
        tick(); tick();
        reset = 1'b0;
        chk("mrst_no_start", start_cnt - s0, 0);
        send_cfg(2'b00, 1'b0, 1'b1);
        chk("mrst_reuse_key_clr", key, 256'h0);
        load_words(k128, 4, 0);
        load_words(blk1, 4, 0);
        wait_start();
        tick();
        chk("mrst_full_latency", start_cyc - cfg_cyc, 9);
        chk("mrst_key_after", key, {32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 128'h0});
        finish_op();
        chk("err_pulse_total", err_pulses, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
